// File: rtl/rpl_requester.sv
// Client-side requester for one resource pool lock port: accepts an op, requests a
// resource, holds it until done/flush, then issues a single-cycle release.
module rpl_requester #(
    parameter int ID_WIDTH     = 8,
    parameter int RES_ID_WIDTH = 1,
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_W        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [ID_WIDTH-1:0]     op_issue_id,
    input  logic                    op_oneshot,
    input  logic                    done,
    input  logic                    flush,
    // packed as {req, req_issue_id, release_lock}
    output logic [ID_WIDTH+1:0]     rpl_out,
    input  logic                    grant,
    input  logic [RES_ID_WIDTH-1:0] alloc_id,
    output logic                    gnt_pulse,
    output logic [RES_ID_WIDTH-1:0] gnt_id,
    output logic                    held_valid,
    output logic                    starved,
    output logic                    lost_grant
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, REL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    state_t             state, state_nxt;
    logic [ID_WIDTH-1:0] id_q;
    logic               oneshot_q;
    logic [CNT_W-1:0]   cnt;
    logic               take;       // resource won this cycle: pulse and capture id
    logic               lose;       // grant dropped while holding

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        lose      = 1'b0;
        case (state)
            IDLE: if (op_valid) state_nxt = REQ;
            REQ: begin
                if (grant) begin
                    if (oneshot_q) begin
                        take      = 1'b1;
                        state_nxt = IDLE;
                    end else if (!flush) begin
                        take      = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        // pool already marked us owner, so it must be told to free it
                        state_nxt = REL;
                    end
                end else if (flush) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (done || flush) state_nxt = REL;
                else if (!grant)   lose      = 1'b1;
            end
            REL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            id_q       <= '0;
            oneshot_q  <= 1'b0;
            cnt        <= '0;
            gnt_pulse  <= 1'b0;
            gnt_id     <= '0;
            lost_grant <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt_pulse <= take;
            if (state == IDLE && op_valid) begin
                id_q      <= op_issue_id;
                oneshot_q <= op_oneshot;
            end
            if (take) gnt_id <= alloc_id;
            if (lose) lost_grant <= 1'b1;
            if (state == REQ && state_nxt == REQ) begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // All pool-facing fields come from registered state only.
    assign op_ready   = (state == IDLE);
    assign held_valid = (state == HOLD);
    assign starved    = (state == REQ) && (cnt >= LIMIT);
    assign rpl_out    = {state == REQ, id_q, (state == REL) || (state == REQ && oneshot_q)};

endmodule
